// File: rtl/cmult_pkg.sv
// Shared widths, data types and sequencer state encoding for the complex-multiply FIR datapath.
package cmult_pkg;

    localparam int SAMP_W = 25;
    localparam int COEF_W = 27;
    localparam int PROD_W = 52;
    localparam int ACC_W  = 56;

    typedef logic signed [ACC_W-1:0]  Sum;
    typedef logic signed [COEF_W-1:0] Coef;
    typedef logic signed [PROD_W-1:0] Partial_product;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cmult_accum.sv
// Complex I/Q accumulator with synchronous clear and enable.
// CMULT_SAT_EN: the final accumulation is clamped to the partial-product range.
module cmult_accum #(
    parameter int PROD_W = 52,
    parameter int ACC_W  = 56
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_en,
`ifdef CMULT_SAT_EN
    input  logic                     i_last,
`endif
    input  logic signed [PROD_W-1:0] i_pp_i,
    input  logic signed [PROD_W-1:0] i_pp_q,
    output logic signed [ACC_W-1:0]  o_acc_i,
    output logic signed [ACC_W-1:0]  o_acc_q
);

    localparam int EXT = ACC_W - PROD_W;

    logic signed [ACC_W-1:0] r_acc_i, r_acc_q;
    logic signed [ACC_W-1:0] w_sum_i, w_sum_q;
    logic signed [ACC_W-1:0] w_nxt_i, w_nxt_q;

    assign w_sum_i = r_acc_i + {{EXT{i_pp_i[PROD_W-1]}}, i_pp_i};
    assign w_sum_q = r_acc_q + {{EXT{i_pp_q[PROD_W-1]}}, i_pp_q};

`ifdef CMULT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(EXT+1){1'b0}}, {(PROD_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) return SAT_HI;
        if (v < SAT_LO) return SAT_LO;
        return v;
    endfunction

    // Clamp folds into the closing add so the result lands in DONE with no extra cycle.
    assign w_nxt_i = i_last ? clamp(w_sum_i) : w_sum_i;
    assign w_nxt_q = i_last ? clamp(w_sum_q) : w_sum_q;
`else
    assign w_nxt_i = w_sum_i;
    assign w_nxt_q = w_sum_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (i_clear) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (i_en) begin
            r_acc_i <= w_nxt_i;
            r_acc_q <= w_nxt_q;
        end
    end

    assign o_acc_i = r_acc_i;
    assign o_acc_q = r_acc_q;

endmodule

// File: rtl/cmult_tap_sequencer.sv
// Drives one FIR output through the pipelined complex multiplier: issues taps, tracks
// in-flight products, accumulates them and hands the sum off on valid/ready. Option: CMULT_SAT_EN.
module cmult_tap_sequencer
    import cmult_pkg::*;
#(
    parameter int NTAPS    = 16,
    parameter int MULT_LAT = 3,
    parameter int PROD_W   = cmult_pkg::PROD_W,
    parameter int ACC_W    = cmult_pkg::ACC_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_valid,
    output logic                       start_ready,
    output logic [$clog2(NTAPS)-1:0]   tap_idx,
    output logic                       tap_issue,
    output logic                       first_tap,
    input  logic signed [PROD_W-1:0]   pp_I,
    input  logic signed [PROD_W-1:0]   pp_Q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_W-1:0]    acc_I,
    output logic signed [ACC_W-1:0]    acc_Q
);

    localparam int                  IDX_W    = $clog2(NTAPS);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NTAPS - 1);
    localparam logic [MULT_LAT-1:0] TAIL     = MULT_LAT'(1) << (MULT_LAT - 1);

    seq_state_t          r_state, w_state_nxt;
    logic [MULT_LAT-1:0] r_vld_pipe;
    logic [IDX_W-1:0]    r_tap_idx;

    logic w_issue, w_qual, w_last_pp, w_start_acc;

    assign w_issue     = (r_state == ISSUE);
    assign w_qual      = r_vld_pipe[MULT_LAT-1];
    // Final product: tail valid with nothing behind it, once issuing has stopped.
    assign w_last_pp   = (r_state == DRAIN) && w_qual && ((r_vld_pipe & ~TAIL) == '0);
    assign start_ready = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_start_acc = start_valid && start_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_state_nxt = ISSUE;
            ISSUE:   if (r_tap_idx == LAST_IDX) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_pp || (r_vld_pipe == '0)) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = start_valid ? ISSUE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_vld_pipe <= '0;
            r_tap_idx  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vld_pipe <= MULT_LAT'({r_vld_pipe, w_issue});
            if (w_start_acc)
                r_tap_idx <= '0;
            else if (w_issue)
                r_tap_idx <= (r_tap_idx == LAST_IDX) ? '0 : r_tap_idx + IDX_W'(1);
        end
    end

    cmult_accum #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start_acc),
        .i_en    (w_qual),
`ifdef CMULT_SAT_EN
        .i_last  (w_last_pp),
`endif
        .i_pp_i  (pp_I),
        .i_pp_q  (pp_Q),
        .o_acc_i (acc_I),
        .o_acc_q (acc_Q)
    );

    assign tap_idx   = r_tap_idx;
    assign tap_issue = w_issue;
    assign first_tap = w_issue && (r_tap_idx == '0);
    assign out_valid = (r_state == DONE);

endmodule
